enigma_stream: RTL and testbench

Byte-stream front end for the Enigma cipher core. It accepts plaintext or ciphertext bytes from an upstream valid/ready source and issues each letter to the core as a single-cycle valid pulse with its byte. It then waits for the core's done pulse and presents the result downstream on a valid/ready port. Non-letter bytes bypass the core unchanged, and byte order is preserved.

---
 rtl/enigma_stream.sv | 112 +++++++++++
 tb/tb_enigma_stream.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_stream.sv
// enigma_stream: byte-stream front end for the Enigma cipher core.
// Upstream bytes arrive on a valid/ready port. Letters are folded to lowercase
// and issued to the core as a one-cycle pulse. The block then waits for the
// core's done pulse, or for a timeout, and presents the result downstream.
// Non-letters bypass the core unchanged. Only one byte is in flight at a time,
// so byte order is preserved.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   s_valid/s_ready      upstream handshake; s_data byte, s_last end of message
//   core_valid/core_din  one-cycle issue pulse and lowercase letter to the core
//   core_done/core_dout  core result pulse and result byte
//   m_valid/m_ready      downstream handshake; m_data byte, m_last flag
//   busy                 high whenever the FSM is not in IDLE
//   timeout_err          sticky flag for core timeouts, cleared only by reset
module enigma_stream #(
  parameter logic [15:0] TIMEOUT  = 16'd1023,
  parameter logic [7:0]  ERR_CHAR = 8'h3F
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       core_valid,
  output logic [7:0] core_din,
  input  logic       core_done,
  input  logic [7:0] core_dout,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  letter;
  logic [7:0]  out_data;
  logic        out_last;
  logic [15:0] timer;
  logic        err;
  logic        is_lower, is_upper, is_letter, expire;

  assign is_lower  = (s_data >= 8'h61) && (s_data <= 8'h7A);
  assign is_upper  = (s_data >= 8'h41) && (s_data <= 8'h5A);
  assign is_letter = is_lower || is_upper;
  // Timer is cleared on the issue cycle, so reaching TIMEOUT-1 in WAIT puts
  // ERR_CHAR on the output TIMEOUT+1 cycles after the issue pulse.
  assign expire    = (timer == (TIMEOUT - 16'd1));

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s_valid) state_nxt = is_letter ? ISSUE : OUT;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (core_done || expire) state_nxt = OUT;
      OUT:     if (m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      letter   <= 8'h00;
      out_data <= 8'h00;
      out_last <= 1'b0;
      timer    <= 16'h0000;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (s_valid) begin
            out_last <= s_last;
            if (is_letter) letter   <= s_data | 8'h20;
            else           out_data <= s_data;
          end
        end
        ISSUE: timer <= 16'h0000;
        WAIT: begin
          timer <= timer + 16'd1;
          // A done pulse in the expiry cycle still counts as a good result.
          if (core_done) begin
            out_data <= core_dout;
          end else if (expire) begin
            out_data <= ERR_CHAR;
            err      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // All outputs decode registered state only; no path from m_ready to s_ready.
  assign s_ready     = (state == IDLE);
  assign core_valid  = (state == ISSUE);
  assign core_din    = core_valid ? letter : 8'h00;
  assign m_valid     = (state == OUT);
  assign m_data      = out_data;
  assign m_last      = out_last;
  assign busy        = (state != IDLE);
  assign timeout_err = err;

endmodule

// File: tb/tb_enigma_stream.sv
// Testbench for enigma_stream: directed vector table, multi-cycle corner
// sequences (backpressure, timeout, reset in WAIT) and a randomized run
// checked against a behavioural model of the byte stream.
module tb_enigma_stream;

  localparam int          T   = 8;
  localparam logic [7:0]  ERR = 8'h3F;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid, s_ready, s_last;
  logic [7:0] s_data;
  logic       core_valid, core_done;
  logic [7:0] core_din, core_dout;
  logic       m_valid, m_ready, m_last;
  logic [7:0] m_data;
  logic       busy, timeout_err;

  enigma_stream #(.TIMEOUT(16'(T)), .ERR_CHAR(ERR)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .core_valid(core_valid), .core_din(core_din),
    .core_done(core_done), .core_dout(core_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Core model: answers core_rsp core_lat cycles after the issue pulse;
  // core_lat == 0 means the core never answers.
  int         core_lat = 0;
  logic [7:0] core_rsp = 8'h00;
  logic       mdl_done = 1'b0, man_done = 1'b0;
  logic [7:0] mdl_dout = 8'h00, man_dout = 8'h00;
  assign core_done = mdl_done | man_done;
  assign core_dout = man_done ? man_dout : mdl_dout;

  initial begin
    forever begin
      @(negedge clk);
      if (core_valid && core_lat != 0) begin
        int         l;
        logic [7:0] r;
        l = core_lat;
        r = core_rsp;
        repeat (l) @(negedge clk);
        mdl_done = 1'b1;
        mdl_dout = r;
        @(negedge clk);
        mdl_done = 1'b0;
        mdl_dout = 8'h00;
      end
    end
  end

  int n_cmp = 0, n_bad = 0;
  bit err_exp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] din;
    logic       last;
    int         lat;
    logic [7:0] rsp;
    int         hold;
    logic [7:0] nxt;
    bit         has_nxt;
    bit         exp_core;
    logic [7:0] exp_din;
    logic [7:0] exp_dout;
    logic       exp_last;
    int         exp_gap;
    bit         exp_to;
  } vec_t;

  // Sends one byte and checks issue, result, timing, backpressure and flags.
  // Called and returns at a negedge.
  task automatic xfer(input vec_t v);
    int  n, cyc, cv_cnt, issue_cyc;
    bit  got, din_bad, hold_bad;
    logic [7:0] hd;
    logic       hl;
    core_lat = v.lat;
    core_rsp = v.rsp;
    s_valid  = 1'b1;
    s_data   = v.din;
    s_last   = v.last;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_bound", 0, 1);
    @(negedge clk);
    s_valid = 1'b0;
    cyc = 0; cv_cnt = 0; issue_cyc = -1; got = 1'b0; din_bad = 1'b0;
    while (cyc < 100) begin
      if (core_valid) begin
        cv_cnt++;
        issue_cyc = cyc;
        chk("core_din", core_din, v.exp_din);
      end else if (core_din !== 8'h00) din_bad = 1'b1;
      if (m_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk("mvalid_bound", got, 1);
    chk("core_pulses", cv_cnt, v.exp_core ? 1 : 0);
    chk("din_idle_zero", din_bad, 0);
    if (v.exp_core) chk("issue_cycle", issue_cyc, 0);
    chk("result_gap", cyc, v.exp_gap);
    chk("m_data", m_data, v.exp_dout);
    chk("m_last", m_last, v.exp_last);
    chk("busy_out", busy, 1);
    hd = m_data; hl = m_last; hold_bad = 1'b0;
    for (int i = 0; i < v.hold; i++) begin
      if (v.has_nxt) begin
        s_valid = 1'b1;
        s_data  = v.nxt;
      end
      @(negedge clk);
      if (!m_valid || m_data !== hd || m_last !== hl || s_ready || core_valid)
        hold_bad = 1'b1;
    end
    if (v.hold > 0) chk("hold_stable", hold_bad, 0);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("busy_after", busy, 0);
    chk("s_ready_after", s_ready, 1);
    err_exp = err_exp | v.exp_to;
    chk("timeout_err", timeout_err, err_exp);
  endtask

  // Behavioural model: what the stream should emit for a byte.
  function automatic vec_t model(input logic [7:0] b, input logic l, input int lat,
                                 input logic [7:0] rsp, input int hold);
    vec_t v;
    bit up, lo;
    up = (b >= "A") && (b <= "Z");
    lo = (b >= "a") && (b <= "z");
    v.din = b; v.last = l; v.lat = lat; v.rsp = rsp; v.hold = hold;
    v.nxt = 8'h00; v.has_nxt = 1'b0;
    v.exp_last = l;
    v.exp_core = up || lo;
    v.exp_din  = up ? b - "A" + "a" : (lo ? b : 8'h00);
    if (!(up || lo)) begin
      v.exp_dout = b; v.exp_gap = 0; v.exp_to = 1'b0;
    end else if (lat >= 1 && lat <= T) begin
      v.exp_dout = rsp; v.exp_gap = lat + 1; v.exp_to = 1'b0;
    end else begin
      v.exp_dout = ERR; v.exp_gap = T + 1; v.exp_to = 1'b1;
    end
    return v;
  endfunction

  vec_t tbl [13];

  initial begin
    //            din   l  lat rsp   hold nxt   hn core din   dout  l  gap to
    tbl[0]  = '{8'h68, 0, 3, 8'h71, 0, 8'h00, 0, 1, 8'h68, 8'h71, 0, 4, 0};
    tbl[1]  = '{8'h48, 1, 1, 8'h55, 0, 8'h00, 0, 1, 8'h68, 8'h55, 1, 2, 0};
    tbl[2]  = '{8'h20, 1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h20, 1, 0, 0};
    tbl[3]  = '{8'h5A, 0, 8, 8'h41, 0, 8'h00, 0, 1, 8'h7A, 8'h41, 0, 9, 0};
    tbl[4]  = '{8'h40, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h40, 0, 0, 0};
    tbl[5]  = '{8'h5B, 1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h5B, 1, 0, 0};
    tbl[6]  = '{8'h60, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h60, 0, 0, 0};
    tbl[7]  = '{8'h7B, 1, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h7B, 1, 0, 0};
    tbl[8]  = '{8'h61, 0, 2, 8'h62, 5, 8'h62, 1, 1, 8'h61, 8'h62, 0, 3, 0};
    tbl[9]  = '{8'h62, 1, 4, 8'h63, 0, 8'h00, 0, 1, 8'h62, 8'h63, 1, 5, 0};
    tbl[10] = '{8'h41, 0, 7, 8'h10, 0, 8'h00, 0, 1, 8'h61, 8'h10, 0, 8, 0};
    tbl[11] = '{8'h7A, 0, 0, 8'h00, 2, 8'h00, 0, 1, 8'h7A, 8'h3F, 0, 9, 1};
    tbl[12] = '{8'h6D, 1, 2, 8'h5A, 0, 8'h00, 0, 1, 8'h6D, 8'h5A, 1, 3, 0};

    reset = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_core_valid", core_valid, 0);
    chk("rst_core_din", core_din, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);

    for (int i = 0; i < 13; i++) xfer(tbl[i]);

    // Reset while waiting on the core; a late done must not leak out.
    core_lat = 0;
    s_valid = 1'b1; s_data = 8'h63; s_last = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("wait_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    err_exp = 1'b0;
    chk("wrst_s_ready", s_ready, 1);
    chk("wrst_core_valid", core_valid, 0);
    chk("wrst_core_din", core_din, 0);
    chk("wrst_m_valid", m_valid, 0);
    chk("wrst_m_data", m_data, 0);
    chk("wrst_m_last", m_last, 0);
    chk("wrst_busy", busy, 0);
    chk("wrst_timeout_err", timeout_err, 0);
    man_done = 1'b1; man_dout = 8'h55;
    @(negedge clk);
    man_done = 1'b0; man_dout = 8'h00;
    begin
      bit leak = 1'b0;
      for (int i = 0; i < 5; i++) begin
        if (m_valid || busy) leak = 1'b1;
        @(negedge clk);
      end
      chk("late_done_ignored", leak, 0);
    end

    // Randomized stream against the behavioural model.
    for (int i = 0; i < 150; i++) begin
      logic [7:0] b;
      int sel, lat;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       b = 8'($urandom_range(8'h61, 8'h7A));
        1:       b = 8'($urandom_range(8'h41, 8'h5A));
        default: b = 8'($urandom_range(0, 255));
      endcase
      lat = $urandom_range(0, T);
      xfer(model(b, 1'($urandom_range(0, 1)), lat, 8'($urandom), $urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
